irq_gateway: RTL and testbench
==============================

# irq_gateway

Per-source interrupt gateway between raw peripheral interrupt lines (timer, uart_rx, uart_tx, …) and the PLIC `irq_sources` input. It synchronises each line and applies per-source polarity and edge/level mode. A per-source claim/complete state machine guarantees at most one outstanding request per source. Its `irq_out` vector drives the PLIC directly. Claims come from the CPU trap handler path; completions come from the handler's end-of-interrupt write.

## Interface
Parameters:
- `N_SRC`, 32 — number of sources; ids are `0..N_SRC-1`; max 32.

Ports:
- `clk` input 1 — single clock.
- `reset_n` input 1 — asynchronous, active-low reset.
- `raw_irq` input N_SRC — raw interrupt lines, asynchronous to `clk`.
- `addr` input 32 — config bus address; only `[7:0]` decoded.
- `wdata` input 32 — config write data.
- `we` input 1 — config write strobe, one write per cycle.
- `rdata` output 32 — combinational read data.
- `claim_valid` input 1 — one-cycle claim pulse.
- `claim_id` input 5 — id being claimed.
- `complete_valid` input 1 — one-cycle completion pulse.
- `complete_id` input 5 — id being completed.
- `irq_out` output N_SRC — registered; bit i is 1 iff source i is in PENDING.

## Operation
Register map (`addr[7:0]`):
- 0x00 MODE — RW; 1 = edge, 0 = level.
- 0x04 POL — RW; 1 = active-low.
- 0x08 PEND — RO; PENDING bits.
- 0x0C INFL — RO; INFLIGHT bits.
- Other addresses read 0; writes to them are ignored.

Active signal: `act[i] = sync(raw_irq[i]) ^ POL[i]`.

Edge detect:
- `rise[i] = act[i] & ~prev[i]`; `prev` is registered each cycle.
- `prev` resets to 0, so a source active at reset release produces one rise.

Per-source states: IDLE, PENDING, INFLIGHT, plus a flag `edge_seen` (edge mode only).
- IDLE → PENDING:
  - Level mode: when `act` = 1.
  - Edge mode: when `rise` = 1.
- PENDING → IDLE: level mode only, when `act` drops before a claim (request withdrawn).
- PENDING → PENDING on a further rise: the edges coalesce; the extra edge is not recorded.
- PENDING → INFLIGHT: on `claim_valid` with `claim_id` = i.
- INFLIGHT, edge mode: `rise` sets `edge_seen`; multiple rises coalesce into one.
- INFLIGHT → on `complete_valid` with `complete_id` = i:
  - Edge mode: to PENDING if `edge_seen` is set (which clears `edge_seen`), else to IDLE.
  - Level mode: to IDLE; `act` is re-evaluated on the next cycle.

Ignored handshakes:
- A claim for a source not in PENDING is ignored.
- A complete for a source not in INFLIGHT is ignored.
- An id ≥ `N_SRC` is ignored.

Simultaneous events:
- Claim and complete in the same cycle are independent. Same-id claim and complete cannot both act, because one state excludes the other.
- An edge-mode rise in the same cycle as a claim of that source sets `edge_seen`.
- An edge-mode rise in the same cycle as a complete of that source moves it to PENDING.

Config writes:
- MODE/POL writes do not change the current state.
- Writing MODE bit i to 0 clears `edge_seen[i]`.
- A POL change can itself produce a rise on the next cycle.

## Timing
- Reset (async assert, release synchronous to `clk`): all states IDLE, `edge_seen` = 0, MODE = 0, POL = 0, `prev` = 0, synchroniser flops = 0, `irq_out` = 0. Async reset aborts any in-flight request.
- Source-to-output latency with sync enabled: `raw_irq` sampled at edge k → `irq_out` high after edge k+2 (3 flop stages: sync1, sync2, state).
- A claim pulse at edge k clears `irq_out[i]` after edge k.
- Completion (edge mode with `edge_seen`) at edge k sets `irq_out[i]` after edge k.
- `rdata` reflects register state in the same cycle it is addressed. A write is visible on the cycle after `we`.

## Configuration
`IRQ_GW_SYNC_EN`:
- Defined: each `raw_irq` bit passes through a 2-flop synchroniser (reset 0) before polarity and edge logic; latency as in Timing.
- Undefined: `raw_irq` is treated as already synchronous to `clk` and used directly. Latency drops by 2 cycles: sampled at edge k → `irq_out` after edge k.

## Test plan
- Reset with `raw_irq` = 0: `irq_out` = 0, `rdata` = 0 at 0x00/0x04/0x08/0x0C. Assert `reset_n` = 0 mid-INFLIGHT: INFL reads 0 immediately after reset.
- Level, source 1, POL = 0: raise `raw_irq[1]` → `irq_out[1]` = 1 after 3 edges. Drop it before claim → `irq_out[1]` = 0 after 3 edges. Raise again, claim id 1 → INFL = 0x2, `irq_out[1]` = 0. Complete with line still high → PEND = 0x2 two cycles later.
- Edge, source 0: write MODE = 0x1. Pulse `raw_irq[0]` 3 times while PENDING → one claim, then complete → IDLE (coalesced). Pulse during INFLIGHT, then complete → `irq_out[0]` = 1 the cycle after.
- Polarity: POL = 0x4, level mode, `raw_irq[2]` = 0 → PEND bit 2 set. Write POL = 0 → bit clears.
- Illegal handshakes: claim id 5 while IDLE, complete id 3 while PENDING, claim id 31 with `N_SRC` = 8 → no state change.
- Same cycle: claim id 1 plus complete id 0 (INFLIGHT) → both take effect. Edge rise on source 0 coincident with its complete → PENDING.

Source files
------------

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: polarity, edge/level mode and a claim/complete
// state machine per source feeding the PLIC. Define IRQ_GW_SYNC_EN to add a
// 2-flop synchroniser on each raw_irq line.
module irq_gateway #(
  parameter int unsigned N_SRC = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] raw_irq,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  input  logic             claim_valid,
  input  logic [4:0]       claim_id,
  input  logic             complete_valid,
  input  logic [4:0]       complete_id,
  output logic [N_SRC-1:0] irq_out
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PENDING  = 2'd1,
    S_INFLIGHT = 2'd2
  } src_state_e;

  src_state_e       state_q [N_SRC];
  src_state_e       state_d [N_SRC];
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] pol_q;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] edge_seen_q;
  logic [N_SRC-1:0] edge_seen_d;
  logic [N_SRC-1:0] raw_s;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] claim_hit;
  logic [N_SRC-1:0] cmpl_hit;
  logic [N_SRC-1:0] pend_vec;
  logic [N_SRC-1:0] infl_vec;
  logic             wr_mode;
  logic             wr_pol;
  logic             unused_bits;

  assign unused_bits = ^{addr[31:8], wdata};

`ifdef IRQ_GW_SYNC_EN
  logic [N_SRC-1:0] sync1_q;
  logic [N_SRC-1:0] sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_irq;
      sync2_q <= sync1_q;
    end
  end

  assign raw_s = sync2_q;
`else
  assign raw_s = raw_irq;
`endif

  assign act  = raw_s ^ pol_q;
  assign rise = act & ~prev_q;

  assign wr_mode = we && (addr[7:0] == 8'h00);
  assign wr_pol  = we && (addr[7:0] == 8'h04);

  // Ids at or above N_SRC never match any loop index, so they are dropped here.
  always_comb begin
    claim_hit = '0;
    cmpl_hit  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      claim_hit[i] = claim_valid    && (claim_id    == 5'(i));
      cmpl_hit[i]  = complete_valid && (complete_id == 5'(i));
    end
  end

  always_comb begin
    edge_seen_d = edge_seen_q;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      state_d[i] = state_q[i];
    end
    for (int unsigned i = 0; i < N_SRC; i++) begin
      unique case (state_q[i])
        S_IDLE: begin
          if (mode_q[i] ? rise[i] : act[i]) state_d[i] = S_PENDING;
        end
        S_PENDING: begin
          if (claim_hit[i]) begin
            state_d[i] = S_INFLIGHT;
            if (mode_q[i] && rise[i]) edge_seen_d[i] = 1'b1;
          end else if (!mode_q[i] && !act[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        S_INFLIGHT: begin
          // A rise landing on the completion edge counts as a seen edge.
          if (cmpl_hit[i]) begin
            edge_seen_d[i] = 1'b0;
            if (mode_q[i] && (edge_seen_q[i] || rise[i])) state_d[i] = S_PENDING;
            else                                          state_d[i] = S_IDLE;
          end else if (mode_q[i] && rise[i]) begin
            edge_seen_d[i] = 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      if (wr_mode && !wdata[i]) edge_seen_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        state_q[i] <= S_IDLE;
      end
      edge_seen_q <= '0;
      mode_q      <= '0;
      pol_q       <= '0;
      prev_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        state_q[i] <= state_d[i];
      end
      edge_seen_q <= edge_seen_d;
      prev_q      <= act;
      if (wr_mode) mode_q <= wdata[N_SRC-1:0];
      if (wr_pol)  pol_q  <= wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    pend_vec = '0;
    infl_vec = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      pend_vec[i] = (state_q[i] == S_PENDING);
      infl_vec[i] = (state_q[i] == S_INFLIGHT);
    end
  end

  // Decoded straight from the state flops, so the output is registered.
  assign irq_out = pend_vec;

  always_comb begin
    rdata = '0;
    case (addr[7:0])
      8'h00:   rdata[N_SRC-1:0] = mode_q;
      8'h04:   rdata[N_SRC-1:0] = pol_q;
      8'h08:   rdata[N_SRC-1:0] = pend_vec;
      8'h0C:   rdata[N_SRC-1:0] = infl_vec;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_gateway.sv
// Scoreboard bench for irq_gateway (N_SRC = 8): stimulus queues expected
// irq_out/rdata pairs, a negedge monitor pops and compares them.
module tb_irq_gateway;

`ifdef IRQ_GW_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [7:0]  raw_irq;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        claim_valid;
  logic [4:0]  claim_id;
  logic        complete_valid;
  logic [4:0]  complete_id;
  logic [7:0]  irq_out;

  irq_gateway #(.N_SRC(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .raw_irq        (raw_irq),
    .addr           (addr),
    .wdata          (wdata),
    .we             (we),
    .rdata          (rdata),
    .claim_valid    (claim_valid),
    .claim_id       (claim_id),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .irq_out        (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  exp_irq_q [$];
  logic [31:0] exp_rd_q  [$];
  string       name_q    [$];
  logic        obs;
  int          checks;
  int          errors;

  logic [7:0]  m_irq;
  logic [31:0] m_rd;
  string       m_name;

  always @(negedge clk) begin
    if (obs) begin
      if (exp_irq_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: observation with empty scoreboard");
      end else begin
        m_irq  = exp_irq_q.pop_front();
        m_rd   = exp_rd_q.pop_front();
        m_name = name_q.pop_front();
        checks++;
        if (irq_out !== m_irq || rdata !== m_rd) begin
          errors++;
          $display("FAIL %s: irq_out=%h rdata=%h, expected irq_out=%h rdata=%h",
                   m_name, irq_out, rdata, m_irq, m_rd);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr  = {24'h0, a};
    wdata = d;
    we    = 1'b1;
    cyc(1);
    we    = 1'b0;
  endtask

  task automatic claim(input logic [4:0] id);
    claim_valid = 1'b1;
    claim_id    = id;
    cyc(1);
    claim_valid = 1'b0;
  endtask

  task automatic complete(input logic [4:0] id);
    complete_valid = 1'b1;
    complete_id    = id;
    cyc(1);
    complete_valid = 1'b0;
  endtask

  task automatic pulse0();
    raw_irq[0] = 1'b1;
    cyc(1);
    raw_irq[0] = 1'b0;
    cyc(1);
  endtask

  // Observes the current cycle; returns just after the falling edge.
  task automatic chk(input logic [7:0] a, input logic [7:0] e_irq,
                     input logic [31:0] e_rd, input string name);
    addr = {24'h0, a};
    exp_irq_q.push_back(e_irq);
    exp_rd_q.push_back(e_rd);
    name_q.push_back(name);
    obs = 1'b1;
    @(negedge clk);
    #1;
    obs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; obs = 1'b0;
    reset_n = 1'b0; raw_irq = '0; addr = '0; wdata = '0; we = 1'b0;
    claim_valid = 1'b0; claim_id = '0; complete_valid = 1'b0; complete_id = '0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    chk(8'h00, 8'h00, 32'h0, "rst_mode");
    chk(8'h04, 8'h00, 32'h0, "rst_pol");
    chk(8'h08, 8'h00, 32'h0, "rst_pend");
    chk(8'h0C, 8'h00, 32'h0, "rst_infl");

    // Level mode, source 1
    raw_irq[1] = 1'b1; cyc(1 + LAT);
    chk(8'h08, 8'h02, 32'h2, "lvl_pend");
    raw_irq[1] = 1'b0; cyc(1 + LAT);
    chk(8'h08, 8'h00, 32'h0, "lvl_withdraw");
    raw_irq[1] = 1'b1; cyc(1 + LAT);
    claim(5'd1);
    chk(8'h0C, 8'h00, 32'h2, "lvl_claim_infl");
    complete(5'd1);
    chk(8'h08, 8'h00, 32'h0, "lvl_cmpl_idle");
    cyc(1);
    chk(8'h08, 8'h02, 32'h2, "lvl_repend");
    raw_irq[1] = 1'b0; cyc(1 + LAT);
    chk(8'h08, 8'h00, 32'h0, "lvl_drop");

    // Edge mode, source 0
    wr(8'h00, 32'h1);
    chk(8'h00, 8'h00, 32'h1, "mode_rd");
    pulse0(); pulse0(); pulse0(); cyc(LAT);
    chk(8'h08, 8'h01, 32'h1, "edge_pend");
    claim(5'd0);
    chk(8'h0C, 8'h00, 32'h1, "edge_claim");
    complete(5'd0);
    chk(8'h08, 8'h00, 32'h0, "edge_coalesce_idle");
    pulse0(); cyc(LAT);
    claim(5'd0);
    pulse0(); cyc(LAT);
    chk(8'h0C, 8'h00, 32'h1, "edge_infl_hold");
    complete(5'd0);
    chk(8'h08, 8'h01, 32'h1, "edge_seen_repend");
    claim(5'd0);
    complete(5'd0);
    chk(8'h08, 8'h00, 32'h0, "edge_seen_cleared");

    // Polarity, level mode
    wr(8'h00, 32'h0);
    wr(8'h04, 32'h4);
    chk(8'h04, 8'h00, 32'h4, "pol_rd");
    cyc(1);
    chk(8'h08, 8'h04, 32'h4, "pol_pend");
    wr(8'h04, 32'h0);
    cyc(1);
    chk(8'h08, 8'h00, 32'h0, "pol_clear");

    // Ignored handshakes with source 3 pending
    wr(8'h04, 32'h8);
    cyc(1);
    claim(5'd5);
    complete(5'd3);
    claim(5'd31);
    claim(5'd27);
    chk(8'h08, 8'h08, 32'h8, "illegal_pend");
    chk(8'h0C, 8'h08, 32'h0, "illegal_infl");
    wr(8'h04, 32'h0);
    cyc(1);
    chk(8'h10, 8'h00, 32'h0, "unmapped_rd");

    // Same-cycle claim of 1 and complete of 0
    wr(8'h00, 32'h1);
    raw_irq[1] = 1'b1;
    pulse0(); cyc(LAT);
    claim(5'd0);
    chk(8'h0C, 8'h02, 32'h1, "pre_same");
    claim_valid = 1'b1; claim_id = 5'd1;
    complete_valid = 1'b1; complete_id = 5'd0;
    cyc(1);
    claim_valid = 1'b0; complete_valid = 1'b0;
    chk(8'h0C, 8'h00, 32'h2, "same_cyc_infl");
    raw_irq[1] = 1'b0; cyc(1 + LAT);
    complete(5'd1);
    chk(8'h08, 8'h00, 32'h0, "post_same");

    // Rise coincident with complete
    pulse0(); cyc(LAT);
    claim(5'd0);
    raw_irq[0] = 1'b1; cyc(LAT);
    complete(5'd0);
    chk(8'h08, 8'h01, 32'h1, "rise_cmpl_pend");
    raw_irq[0] = 1'b0; cyc(1 + LAT);

    // Async reset while in flight
    claim(5'd0);
    chk(8'h0C, 8'h00, 32'h1, "infl_before_rst");
    reset_n = 1'b0;
    #1;
    chk(8'h0C, 8'h00, 32'h0, "rst_abort_infl");
    chk(8'h00, 8'h00, 32'h0, "rst_abort_mode");
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
    chk(8'h08, 8'h00, 32'h0, "post_rst_pend");

    for (int i = 0; i < 10 && exp_irq_q.size() != 0; i++) @(negedge clk);
    if (exp_irq_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_irq_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
